// File: rtl/song_sequencer.sv
// Playlist sequencer: play/pause/skip control plus auto-advance with a silent gap between songs.
// All outputs registered; optional shuffle selection when SONG_SEQUENCER_SHUFFLE_EN is defined.
module song_sequencer #(
    parameter int NUM_SONGS  = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play_button,
    input  logic       next_button,
    input  logic       prev_button,
    input  logic [1:0] repeat_mode,
    input  logic       song_done,
    output logic       play,
    output logic [1:0] song,
    output logic       reset_player,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        PAUSED  = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic [1:0]  LAST_SONG = 2'(NUM_SONGS - 1);
    localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES);

    state_t      cur_state, nxt_state;
    logic [1:0]  nxt_song;
    logic [15:0] gap_cnt, nxt_gap_cnt;
    logic        nxt_reset_player;
    logic [1:0]  song_inc, song_dec, song_skip;

    assign song_inc = (song == LAST_SONG) ? 2'd0 : song + 2'd1;
    assign song_dec = (song == 2'd0) ? LAST_SONG : song - 2'd1;

`ifdef SONG_SEQUENCER_SHUFFLE_EN
    logic [7:0] lfsr;
    logic [1:0] shuffle_pick;

    // x^8+x^6+x^5+x^4+1, free-running so the pick depends on when the skip happens
    always_ff @(posedge clk) begin
        if (!reset) lfsr <= 8'hA5;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign shuffle_pick = 2'(lfsr % 8'(NUM_SONGS));
    assign song_skip    = (shuffle_pick != song) ? shuffle_pick :
                          (shuffle_pick == LAST_SONG) ? 2'd0 : shuffle_pick + 2'd1;
`else
    assign song_skip = song_inc;
`endif

    always_comb begin
        nxt_state        = cur_state;
        nxt_song         = song;
        nxt_gap_cnt      = gap_cnt;
        nxt_reset_player = 1'b0;
        case (cur_state)
            IDLE: begin
                if (play_button) begin
                    nxt_state        = PLAYING;
                    nxt_reset_player = 1'b1;
                end else if (next_button) begin
                    nxt_song = song_skip;
                end else if (prev_button) begin
                    nxt_song = song_dec;
                end
            end
            PLAYING: begin
                if (play_button) begin
                    nxt_state = PAUSED;
                end else if (next_button) begin
                    nxt_song         = song_skip;
                    nxt_reset_player = 1'b1;
                end else if (prev_button) begin
                    nxt_song         = song_dec;
                    nxt_reset_player = 1'b1;
                end else if (song_done) begin
                    case (repeat_mode)
                        2'b00: nxt_state = IDLE;
                        2'b01: begin
                            if (song == LAST_SONG) begin
                                nxt_state = IDLE;
                                nxt_song  = 2'd0;
                            end else begin
                                nxt_state   = GAP;
                                nxt_song    = song_inc;
                                nxt_gap_cnt = GAP_LOAD;
                            end
                        end
                        2'b10: begin
                            nxt_state   = GAP;
                            nxt_song    = song_skip;
                            nxt_gap_cnt = GAP_LOAD;
                        end
                        default: begin
                            nxt_state   = GAP;
                            nxt_gap_cnt = GAP_LOAD;
                        end
                    endcase
                end
            end
            PAUSED: begin
                if (play_button) begin
                    nxt_state = PLAYING;
                end else if (next_button) begin
                    nxt_song         = song_skip;
                    nxt_reset_player = 1'b1;
                end else if (prev_button) begin
                    nxt_song         = song_dec;
                    nxt_reset_player = 1'b1;
                end
            end
            default: begin
                // Counter holds the number of silent cycles left, including this one
                if (play_button) begin
                    nxt_state   = IDLE;
                    nxt_gap_cnt = 16'd0;
                end else if (next_button) begin
                    nxt_song    = song_skip;
                    nxt_gap_cnt = GAP_LOAD;
                end else if (prev_button) begin
                    nxt_song    = song_dec;
                    nxt_gap_cnt = GAP_LOAD;
                end else if (gap_cnt <= 16'd1) begin
                    nxt_state        = PLAYING;
                    nxt_gap_cnt      = 16'd0;
                    nxt_reset_player = 1'b1;
                end else begin
                    nxt_gap_cnt = gap_cnt - 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state    <= IDLE;
            song         <= 2'd0;
            gap_cnt      <= 16'd0;
            reset_player <= 1'b0;
            play         <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            song         <= nxt_song;
            gap_cnt      <= nxt_gap_cnt;
            reset_player <= nxt_reset_player;
            play         <= (nxt_state == PLAYING) && !nxt_reset_player;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer (default build): vector table plus hand-written gap/reset sequences.
module tb_song_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       play_button, next_button, prev_button, song_done;
    logic [1:0] repeat_mode;
    logic       play, reset_player;
    logic [1:0] song, state;

    song_sequencer #(.NUM_SONGS(4), .GAP_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
        .prev_button(prev_button), .repeat_mode(repeat_mode), .song_done(song_done),
        .play(play), .song(song), .reset_player(reset_player), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst_n, pb, nb, vb, sd;
        logic [1:0] md;
        logic [1:0] e_state, e_song;
        logic       e_play, e_rp;
    } vec_t;

    vec_t exp_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(string n, logic r, logic p, logic nx, logic pv, logic [1:0] m,
                                logic d, logic [1:0] st, logic [1:0] sg, logic pl, logic rp);
        vec_t v;
        v.name = n; v.rst_n = r; v.pb = p; v.nb = nx; v.vb = pv; v.md = m; v.sd = d;
        v.e_state = st; v.e_song = sg; v.e_play = pl; v.e_rp = rp;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare after the edge
    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        reset = v.rst_n; play_button = v.pb; next_button = v.nb; prev_button = v.vb;
        repeat_mode = v.md; song_done = v.sd;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({state, song, play, reset_player} !== {e.e_state, e.e_song, e.e_play, e.e_rp}) begin
            errors++;
            $display("FAIL %s: got state=%0d song=%0d play=%0b reset_player=%0b, required state=%0d song=%0d play=%0b reset_player=%0b",
                     e.name, state, song, play, reset_player, e.e_state, e.e_song, e.e_play, e.e_rp);
        end
    endtask

    // Remaining 15 silent cycles, then the restart pulse, then play
    task automatic gap_tail(input logic [1:0] sg);
        for (int i = 0; i < 15; i++) step(mk("gap_hold", 1, 0, 0, 0, 2'b00, 0, 2'd3, sg, 0, 0));
        step(mk("gap_end_rp", 1, 0, 0, 0, 2'b00, 0, 2'd1, sg, 0, 1));
        step(mk("gap_end_play", 1, 0, 0, 0, 2'b00, 0, 2'd1, sg, 1, 0));
    endtask

    initial begin
        reset = 1'b0; play_button = 1'b0; next_button = 1'b0; prev_button = 1'b0;
        song_done = 1'b0; repeat_mode = 2'b00;

        //                 name               rst pb nb vb mode  sd  st    song  pl rp
        vecs.push_back(mk("reset",             0, 0, 0, 0, 2'b00, 0, 2'd0, 2'd0, 0, 0));
        vecs.push_back(mk("idle_done_ignored", 1, 0, 0, 0, 2'b10, 1, 2'd0, 2'd0, 0, 0));
        vecs.push_back(mk("idle_next",         1, 0, 1, 0, 2'b00, 0, 2'd0, 2'd1, 0, 0));
        vecs.push_back(mk("idle_prev",         1, 0, 0, 1, 2'b00, 0, 2'd0, 2'd0, 0, 0));
        vecs.push_back(mk("idle_prev_wrap",    1, 0, 0, 1, 2'b00, 0, 2'd0, 2'd3, 0, 0));
        vecs.push_back(mk("idle_next_wrap",    1, 0, 1, 0, 2'b00, 0, 2'd0, 2'd0, 0, 0));
        vecs.push_back(mk("start_rp",          1, 1, 0, 0, 2'b00, 0, 2'd1, 2'd0, 0, 1));
        vecs.push_back(mk("start_play",        1, 0, 0, 0, 2'b00, 0, 2'd1, 2'd0, 1, 0));
        vecs.push_back(mk("pause",             1, 1, 0, 0, 2'b00, 0, 2'd2, 2'd0, 0, 0));
        vecs.push_back(mk("paused_next_rp",    1, 0, 1, 0, 2'b00, 0, 2'd2, 2'd1, 0, 1));
        vecs.push_back(mk("paused_hold",       1, 0, 0, 0, 2'b00, 0, 2'd2, 2'd1, 0, 0));
        vecs.push_back(mk("resume_no_rp",      1, 1, 0, 0, 2'b00, 0, 2'd1, 2'd1, 1, 0));
        vecs.push_back(mk("priority_pause",    1, 1, 1, 0, 2'b00, 1, 2'd2, 2'd1, 0, 0));
        vecs.push_back(mk("resume2",           1, 1, 0, 0, 2'b00, 0, 2'd1, 2'd1, 1, 0));
        vecs.push_back(mk("next_over_prev",    1, 0, 1, 1, 2'b00, 0, 2'd1, 2'd2, 0, 1));
        vecs.push_back(mk("after_skip_play",   1, 0, 0, 0, 2'b00, 0, 2'd1, 2'd2, 1, 0));
        vecs.push_back(mk("prev_over_done",    1, 0, 0, 1, 2'b00, 1, 2'd1, 2'd1, 0, 1));
        vecs.push_back(mk("after_prev_play",   1, 0, 0, 0, 2'b10, 0, 2'd1, 2'd1, 1, 0));
        vecs.push_back(mk("mode00_stop",       1, 0, 0, 0, 2'b00, 1, 2'd0, 2'd1, 0, 0));
        vecs.push_back(mk("restart_rp",        1, 1, 0, 0, 2'b00, 0, 2'd1, 2'd1, 0, 1));
        vecs.push_back(mk("restart_play",      1, 0, 0, 0, 2'b00, 0, 2'd1, 2'd1, 1, 0));
        vecs.push_back(mk("mode11_gap",        1, 0, 0, 0, 2'b11, 1, 2'd3, 2'd1, 0, 0));
        vecs.push_back(mk("gap_play_idle",     1, 1, 0, 0, 2'b00, 0, 2'd0, 2'd1, 0, 0));
        vecs.push_back(mk("to_song0",          1, 0, 0, 1, 2'b00, 0, 2'd0, 2'd0, 0, 0));
        vecs.push_back(mk("to_song3",          1, 0, 0, 1, 2'b00, 0, 2'd0, 2'd3, 0, 0));
        vecs.push_back(mk("song3_rp",          1, 1, 0, 0, 2'b00, 0, 2'd1, 2'd3, 0, 1));
        vecs.push_back(mk("song3_play",        1, 0, 0, 0, 2'b00, 0, 2'd1, 2'd3, 1, 0));
        vecs.push_back(mk("mode01_last_idle",  1, 0, 0, 0, 2'b01, 1, 2'd0, 2'd0, 0, 0));
        vecs.push_back(mk("song0_rp",          1, 1, 0, 0, 2'b00, 0, 2'd1, 2'd0, 0, 1));
        vecs.push_back(mk("song0_play",        1, 0, 0, 0, 2'b00, 0, 2'd1, 2'd0, 1, 0));
        vecs.push_back(mk("mode01_gap",        1, 0, 0, 0, 2'b01, 1, 2'd3, 2'd1, 0, 0));
        vecs.push_back(mk("reset_in_gap",      0, 0, 0, 0, 2'b00, 0, 2'd0, 2'd0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Loop mode from the last song: wrap to 0 after a 16-cycle gap
        step(mk("a_prev3",    1, 0, 0, 1, 2'b00, 0, 2'd0, 2'd3, 0, 0));
        step(mk("a_start_rp", 1, 1, 0, 0, 2'b00, 0, 2'd1, 2'd3, 0, 1));
        step(mk("a_play",     1, 0, 0, 0, 2'b00, 0, 2'd1, 2'd3, 1, 0));
        step(mk("a_mode10",   1, 0, 0, 0, 2'b10, 1, 2'd3, 2'd0, 0, 0));
        gap_tail(2'd0);

        // A skip during the gap reloads the full gap length
        step(mk("b_mode10",   1, 0, 0, 0, 2'b10, 1, 2'd3, 2'd1, 0, 0));
        for (int i = 0; i < 5; i++) step(mk("b_gap_early", 1, 0, 0, 0, 2'b00, 0, 2'd3, 2'd1, 0, 0));
        step(mk("b_gap_next", 1, 0, 1, 0, 2'b00, 0, 2'd3, 2'd2, 0, 0));
        gap_tail(2'd2);

        // Reset with five gap cycles left aborts quietly
        step(mk("c_mode11",   1, 0, 0, 0, 2'b11, 1, 2'd3, 2'd2, 0, 0));
        for (int i = 0; i < 11; i++) step(mk("c_gap_hold", 1, 0, 0, 0, 2'b00, 0, 2'd3, 2'd2, 0, 0));
        step(mk("c_reset",    0, 0, 0, 0, 2'b00, 0, 2'd0, 2'd0, 0, 0));
        for (int i = 0; i < 20; i++) step(mk("c_idle_quiet", 1, 0, 0, 0, 2'b00, 0, 2'd0, 2'd0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
